// File: rtl/param_init_mem.sv
// param_init_mem: single-port synchronous memory that writes word[i] = i after every reset.
// Define MEM_ADDR_CHK_EN to add the err pulse for out-of-range accesses.
module param_init_mem #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned OUT_REG = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              ready,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   output logic              init_done
`ifdef MEM_ADDR_CHK_EN
   ,
   output logic              err
`endif
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam bit          POW2  = ((DEPTH & (DEPTH - 1)) == 0);

   typedef enum logic {StInit, StRun} state_e;

   state_e            state_q;
   logic [IDX_W-1:0]  cnt_q;
   logic [DATA_W-1:0] mem [DEPTH];

   logic [IDX_W-1:0]  idx;
   logic              in_range;
   logic              acc;
   logic              acc_rd;
   logic              mem_we;
   logic [IDX_W-1:0]  mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   logic              rv1_q;
   logic [DATA_W-1:0] rd1_q;

   // Address bits above IDX_W are ignored by design.
   logic unused_addr;
   assign unused_addr = ^addr;

   always_comb begin
      idx       = (DEPTH > 1) ? addr[IDX_W-1:0] : '0;
      in_range  = POW2 || (32'(idx) < DEPTH);
      acc       = en && ready;
      acc_rd    = acc && !wr;
      mem_we    = (state_q == StInit) || (acc && wr && in_range);
      mem_waddr = (state_q == StInit) ? cnt_q : idx;
      mem_wdata = (state_q == StInit) ? DATA_W'(cnt_q) : wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StInit;
         cnt_q     <= '0;
         ready     <= 1'b0;
         init_done <= 1'b0;
      end else begin
         case (state_q)
            StInit: begin
               if (cnt_q == IDX_W'(DEPTH - 1)) begin
                  state_q   <= StRun;
                  ready     <= 1'b1;
                  init_done <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= StRun;
            end
         endcase
      end
   end

   // Array has no reset: the init sweep rewrites every word after reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rv1_q <= 1'b0;
         rd1_q <= '0;
      end else begin
         rv1_q <= acc_rd;
         if (acc_rd) begin
            rd1_q <= in_range ? mem[idx] : '0;
         end
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rvalid <= 1'b0;
               rdata  <= '0;
            end else begin
               rvalid <= rv1_q;
               if (rv1_q) begin
                  rdata <= rd1_q;
               end
            end
         end
      end else begin : g_no_out_reg
         assign rvalid = rv1_q;
         assign rdata  = rd1_q;
      end
   endgenerate

`ifdef MEM_ADDR_CHK_EN
   logic er1_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         er1_q <= 1'b0;
      end else begin
         er1_q <= acc && !in_range;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_err_reg
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               err <= 1'b0;
            end else begin
               err <= er1_q;
            end
         end
      end else begin : g_err_no_reg
         assign err = er1_q;
      end
   endgenerate
`endif

endmodule

// File: tb/tb_param_init_mem.sv
// Bench for param_init_mem: three instances (default, OUT_REG=1, DEPTH=200) checked
// against a timed scoreboard of expected responses.
module tb_param_init_mem;

   typedef struct {
      int       due;
      bit       rd;
      bit       err;
      bit [7:0] data;
   } exp_t;

   typedef struct {
      int       dut;
      bit       wr;
      bit [7:0] addr;
      bit [7:0] wdata;
      bit [7:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic       en0 = 0, wr0 = 0, en1 = 0, wr1 = 0, en2 = 0, wr2 = 0;
   logic [7:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0, addr2 = 0, wdata2 = 0;
   logic       ready0, ready1, ready2, rvalid0, rvalid1, rvalid2, done0, done1, done2;
   logic [7:0] rdata0, rdata1, rdata2;
`ifdef MEM_ADDR_CHK_EN
   logic       err0, err1, err2;
`endif

   param_init_mem #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .OUT_REG(0)) u0 (
      .clk(clk), .rst(rst), .en(en0), .wr(wr0), .addr(addr0), .wdata(wdata0),
      .ready(ready0), .rdata(rdata0), .rvalid(rvalid0), .init_done(done0)
`ifdef MEM_ADDR_CHK_EN
      , .err(err0)
`endif
   );

   param_init_mem #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .OUT_REG(1)) u1 (
      .clk(clk), .rst(rst), .en(en1), .wr(wr1), .addr(addr1), .wdata(wdata1),
      .ready(ready1), .rdata(rdata1), .rvalid(rvalid1), .init_done(done1)
`ifdef MEM_ADDR_CHK_EN
      , .err(err1)
`endif
   );

   param_init_mem #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .OUT_REG(0)) u2 (
      .clk(clk), .rst(rst), .en(en2), .wr(wr2), .addr(addr2), .wdata(wdata2),
      .ready(ready2), .rdata(rdata2), .rvalid(rvalid2), .init_done(done2)
`ifdef MEM_ADDR_CHK_EN
      , .err(err2)
`endif
   );

   exp_t q0[$], q1[$], q2[$];
   exp_t m0, m1, m2;
   vec_t tbl[$];

   function automatic void check(input string nm, input logic [31:0] act,
                                 input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   function automatic void chk_err2(input bit ex);
`ifdef MEM_ADDR_CHK_EN
      if (err2 || ex) check("err2", 32'(err2), 32'(ex));
`endif
   endfunction

   always @(negedge clk) begin
      if (q0.size() > 0 && q0[0].due == cyc) begin
         m0 = q0.pop_front();
         check("rvalid0", 32'(rvalid0), 32'(m0.rd));
         if (m0.rd) check("rdata0", 32'(rdata0), 32'(m0.data));
      end else if (rvalid0) begin
         check("spurious_rvalid0", 32'(rvalid0), 0);
      end
   end

   always @(negedge clk) begin
      if (q1.size() > 0 && q1[0].due == cyc) begin
         m1 = q1.pop_front();
         check("rvalid1", 32'(rvalid1), 32'(m1.rd));
         if (m1.rd) check("rdata1", 32'(rdata1), 32'(m1.data));
      end else if (rvalid1) begin
         check("spurious_rvalid1", 32'(rvalid1), 0);
      end
   end

   always @(negedge clk) begin
      if (q2.size() > 0 && q2[0].due == cyc) begin
         m2 = q2.pop_front();
         check("rvalid2", 32'(rvalid2), 32'(m2.rd));
         if (m2.rd) check("rdata2", 32'(rdata2), 32'(m2.data));
         chk_err2(m2.err);
      end else begin
         if (rvalid2) check("spurious_rvalid2", 32'(rvalid2), 0);
         chk_err2(1'b0);
      end
   end

   function automatic void add(input int d, input bit w, input bit [7:0] a,
                               input bit [7:0] wd, input bit [7:0] ex);
      vec_t v;
      v.dut = d; v.wr = w; v.addr = a; v.wdata = wd; v.exp = ex;
      tbl.push_back(v);
   endfunction

   // Drive one request for a cycle and queue its expected response.
   task automatic issue(input int d, input bit w, input bit [7:0] a, input bit [7:0] wd,
                        input bit [7:0] ex);
      exp_t e;
      e.due  = cyc + ((d == 1) ? 2 : 1);
      e.rd   = !w;
      e.data = w ? 8'h00 : ex;
      e.err  = (d == 2) && (a >= 8'd200);
      case (d)
         0: begin en0 = 1; wr0 = w; addr0 = a; wdata0 = wd; q0.push_back(e); end
         1: begin en1 = 1; wr1 = w; addr1 = a; wdata1 = wd; q1.push_back(e); end
         default: begin en2 = 1; wr2 = w; addr2 = a; wdata2 = wd; q2.push_back(e); end
      endcase
      @(negedge clk);
      en0 = 0; en1 = 0; en2 = 0;
   endtask

   // Count cycles from reset release until each ready rises; optionally hammer u0 with writes.
   task automatic wait_init(input bit spam, output int k0, output int k1, output int k2);
      k0 = 0; k1 = 0; k2 = 0;
      for (int k = 1; k <= 400; k++) begin
         if (spam && k0 == 0) begin
            en0 = 1; wr0 = 1; addr0 = 8'(k); wdata0 = 8'hEE;
         end
         @(negedge clk);
         if (ready0 && k0 == 0) begin k0 = k; en0 = 0; end
         if (ready1 && k1 == 0) k1 = k;
         if (ready2 && k2 == 0) k2 = k;
         if (k0 != 0 && k1 != 0 && k2 != 0) break;
      end
      en0 = 0; wr0 = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1);
   end

   initial begin
      int k0, k1, k2;

      add(0, 0, 8'd3,   8'h00, 8'd3);
      add(0, 0, 8'd15,  8'h00, 8'd15);
      add(0, 0, 8'd20,  8'h00, 8'd20);
      add(0, 0, 8'd22,  8'h00, 8'd22);
      add(0, 1, 8'h10,  8'hA5, 8'h00);
      add(0, 0, 8'h10,  8'h00, 8'hA5);
      add(1, 0, 8'd0,   8'h00, 8'd0);
      add(1, 0, 8'd1,   8'h00, 8'd1);
      add(1, 0, 8'd2,   8'h00, 8'd2);
      add(1, 0, 8'd3,   8'h00, 8'd3);
      add(2, 1, 8'd250, 8'hFF, 8'h00);
      add(2, 0, 8'd250, 8'h00, 8'h00);
      add(2, 0, 8'd199, 8'h00, 8'd199);
      add(2, 0, 8'd200, 8'h00, 8'h00);
      add(2, 1, 8'd10,  8'h3C, 8'h00);
      add(2, 0, 8'd10,  8'h00, 8'h3C);
      add(0, 0, 8'd5,   8'h00, 8'd5);
      add(0, 0, 8'd255, 8'h00, 8'd255);
      add(0, 0, 8'h11,  8'h00, 8'h11);

      repeat (3) @(negedge clk);
      check("rst_ready0", 32'(ready0), 0);
      check("rst_done0", 32'(done0), 0);
      check("rst_rvalid0", 32'(rvalid0), 0);
      check("rst_rdata0", 32'(rdata0), 0);
      check("rst_rdata1", 32'(rdata1), 0);
      check("rst_ready2", 32'(ready2), 0);
`ifdef MEM_ADDR_CHK_EN
      check("rst_err2", 32'(err2), 0);
`endif
      rst = 1'b0;

      // Writes during the sweep must be ignored.
      wait_init(1'b1, k0, k1, k2);
      check("init_cycles0", k0, 256);
      check("init_cycles1", k1, 256);
      check("init_cycles2", k2, 200);
      check("init_done0", 32'(done0), 1);
      check("init_done2", 32'(done2), 1);

      for (int i = 0; i < tbl.size(); i++) begin
         issue(tbl[i].dut, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp);
      end
      repeat (4) @(negedge clk);
      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);
      check("q2_drained", q2.size(), 0);
      check("rdata0_hold", 32'(rdata0), 8'h11);
      check("rdata1_hold", 32'(rdata1), 8'd3);

      // Read accepted, then reset before the response arrives.
      en0 = 1; wr0 = 0; addr0 = 8'd3;
      en1 = 1; wr1 = 0; addr1 = 8'd3;
      @(posedge clk);
      #1 rst = 1'b1;
      en0 = 0; en1 = 0;
      @(negedge clk);
      check("drop_rvalid0", 32'(rvalid0), 0);
      check("drop_rvalid1", 32'(rvalid1), 0);
      check("drop_ready0", 32'(ready0), 0);
      check("drop_done0", 32'(done0), 0);
      check("drop_rdata0", 32'(rdata0), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (100) @(negedge clk);
      check("midsweep_ready0", 32'(ready0), 0);
      check("midsweep_rvalid1", 32'(rvalid1), 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      wait_init(1'b0, k0, k1, k2);
      check("reinit_cycles0", k0, 256);
      check("reinit_cycles1", k1, 256);
      check("reinit_cycles2", k2, 200);

      // Contents rewritten by the new sweep.
      issue(0, 0, 8'h10, 8'h00, 8'h10);
      issue(2, 0, 8'd10, 8'h00, 8'd10);
      issue(1, 0, 8'hFE, 8'h00, 8'hFE);
      issue(2, 0, 8'd250, 8'h00, 8'h00);
      repeat (4) @(negedge clk);
      check("q0_final", q0.size(), 0);
      check("q1_final", q1.size(), 0);
      check("q2_final", q2.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
